switch_allocator: RTL
=====================

# switch_allocator

Per-router switch allocator for the NoC. It arbitrates input-port flit requests for each output port with per-output round-robin priority. It holds wormhole locks from a head flit through its tail flit and drives the grant and port-select inputs of the router crossbar. Grants are combinational from the current requests plus registered lock/priority state; a flit transfers on the clock edge where its grant is high.

## Interface
- IN_PORTS, 5, number of router input ports
- OUT_PORTS, 5, number of router output ports
- OUT_PORT_BITS, 3, width of one output-port index
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- ON  input  1  allocator enable; 0 freezes state and suppresses grants
- req_valid  input  IN_PORTS  input i presents a flit
- req_ports  input  IN_PORTS*OUT_PORT_BITS  requested output of input i, slice [(i+1)*OUT_PORT_BITS-1 -: OUT_PORT_BITS]
- req_head  input  IN_PORTS  flit on input i is a head flit
- req_tail  input  IN_PORTS  flit on input i is a tail flit (head&tail = single-flit packet)
- out_ready  input  OUT_PORTS  downstream of output o can accept a flit this cycle
- grants  output  IN_PORTS  input i's flit is transferred at this edge (to crossbar grants)
- grant_ports  output  IN_PORTS*OUT_PORT_BITS  req_ports passed through, bit-for-bit (to crossbar req_ports)
- out_locked  output  OUT_PORTS  output o is held by an in-progress packet

## Operation
- State per output o: lock[o] (1 b), owner[o] (input index), ptr[o] (round-robin pointer, 0..IN_PORTS-1).
- Requests with req_ports >= OUT_PORTS are never granted and change no state.
- Locked output o: grant owner[o] iff req_valid[owner], req_ports[owner]==o, out_ready[o]. All other requesters for o get 0, including head flits.
- Unlocked output o: candidates are inputs with req_valid, req_head, req_ports==o. Winner is the first candidate scanning ptr[o], ptr[o]+1, … mod IN_PORTS. It is granted iff out_ready[o].
- Non-head flit to an unlocked output: never granted (protocol error, no state change).
- On a granted head without tail: lock[o]<=1, owner[o]<=winner.
- On a granted tail (including head&tail): lock[o]<=0.
- ptr[o]<=winner+1 mod IN_PORTS on every granted head. ptr is unchanged otherwise, including when out_ready blocks the winner.
- Each input requests at most one output, so grants has no input-side conflicts. At most one grant per output per cycle.
- out_locked = lock.
- ON=0: grants=0; lock/owner/ptr hold.

## Timing
- Reset (reset==0, asynchronous): lock=0, owner=0, ptr=0. grants forced 0 while reset is low. out_locked=0.
- grants and grant_ports are combinational: zero-cycle latency from req_* / out_ready.
- The crossbar registers data, so flit data and valid reach the output one edge after the grant.
- Handshake: an input holds req_valid/ports/head/tail stable until the edge where its grant is 1. It may present the next flit in the following cycle, giving a sustained one flit/cycle per packet.
- Lock and pointer updates take effect for the cycle after the granting edge.
- Simultaneous release and new head at one output: the tail grant releases at the edge. A competing head is granted no earlier than the next cycle.
- Reset mid-packet drops all locks; the upstream is flushed by the same reset.

## Structure
- Shared package noc_pkg: IN_PORTS/OUT_PORTS/OUT_PORT_BITS defaults and port-index constants (LOCAL, NORTH, EAST, SOUTH, WEST).
- One sub-module rr_arbiter (request vector, pointer -> one-hot grant, winner index), instantiated OUT_PORTS times in a generate loop. Lock/owner/ptr registers live in switch_allocator.

## Test plan
- Reset: hold reset=0 with all req_valid=1 -> grants=0, out_locked=0. Release and request in0->out2 head&tail, out_ready=all 1 -> grants=00001 same cycle, ptr[2]=1 after the edge.
- Contention: in0, in1, in3 heads to out4, single-flit, held for 3 edges -> grants 00001, 00010, 01000 on successive cycles.
- Wormhole: in2 sends a 4-flit packet to out1 (H,B,B,T) while in0 heads to out1 -> in2 granted 4 consecutive cycles, out_locked[1]=1 for 3 of them, in0 granted on cycle 5.
- Backpressure: out_ready[3]=0 for 2 cycles with in4 head to out3 -> grants=0 and ptr[3] unchanged. out_ready[3]=1 -> granted.
- Invalid and disable: req_ports=7 on in1 -> never granted. ON=0 mid-packet -> grants=0 with lock held; ON=1 resumes the same owner.
- Async reset mid-packet: reset pulsed low between clock edges while out0 is locked -> out_locked=0 immediately.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router parameters, port indices and small index helpers.
// Imported by the switch allocator, its arbiter and its bus interface.
package noc_pkg;

    localparam int IN_PORTS      = 5;
    localparam int OUT_PORTS     = 5;
    localparam int OUT_PORT_BITS = 3;
    localparam int IN_IDX_BITS   = $clog2(IN_PORTS);

    typedef logic [OUT_PORT_BITS-1:0] port_t;
    typedef logic [IN_IDX_BITS-1:0]   in_idx_t;

    localparam port_t LOCAL = port_t'(0);
    localparam port_t NORTH = port_t'(1);
    localparam port_t EAST  = port_t'(2);
    localparam port_t SOUTH = port_t'(3);
    localparam port_t WEST  = port_t'(4);

    function automatic in_idx_t next_idx(in_idx_t i);
        return (i == in_idx_t'(IN_PORTS - 1)) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between input buffers, allocator and crossbar.
// master = requesters and downstream readiness, slave = allocator.
interface switch_allocator_if;
    import noc_pkg::*;

    logic [IN_PORTS-1:0]               req_valid;
    logic [IN_PORTS*OUT_PORT_BITS-1:0] req_ports;
    logic [IN_PORTS-1:0]               req_head;
    logic [IN_PORTS-1:0]               req_tail;
    logic [OUT_PORTS-1:0]              out_ready;
    logic [IN_PORTS-1:0]               grants;
    logic [IN_PORTS*OUT_PORT_BITS-1:0] grant_ports;
    logic [OUT_PORTS-1:0]              out_locked;

    modport master (
        output req_valid, req_ports, req_head, req_tail, out_ready,
        input  grants, grant_ports, out_locked
    );

    modport slave (
        input  req_valid, req_ports, req_head, req_tail, out_ready,
        output grants, grant_ports, out_locked
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first request at or after the pointer, wrapping.
// Purely combinational; the pointer register lives in the caller.
module rr_arbiter
    import noc_pkg::*;
(
    input  logic [IN_PORTS-1:0] i_req,
    input  in_idx_t             i_ptr,
    output logic [IN_PORTS-1:0] o_gnt,
    output in_idx_t             o_idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < IN_PORTS; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= IN_PORTS) w_j = w_j - IN_PORTS;
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = in_idx_t'(w_j);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-router switch allocator: round-robin per output with wormhole
// locks held from head to tail; grants are combinational.
module switch_allocator
    import noc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ON,
    switch_allocator_if.slave bus
);

    logic                r_lock  [OUT_PORTS];
    in_idx_t             r_owner [OUT_PORTS];
    in_idx_t             r_ptr   [OUT_PORTS];

    port_t               w_port    [IN_PORTS];
    logic [IN_PORTS-1:0] w_cand    [OUT_PORTS];
    logic [IN_PORTS-1:0] w_arb_gnt [OUT_PORTS];
    in_idx_t             w_arb_idx [OUT_PORTS];
    logic [IN_PORTS-1:0] w_ogrant  [OUT_PORTS];
    logic [OUT_PORTS-1:0] w_fire;
    logic [OUT_PORTS-1:0] w_lock_vec;
    logic [IN_PORTS-1:0] w_grants;
    logic                w_en;

    assign w_en = ON & reset;

    for (genvar i = 0; i < IN_PORTS; i++) begin : g_port
        assign w_port[i] =
            bus.req_ports[(i+1)*OUT_PORT_BITS-1 -: OUT_PORT_BITS];
    end

    // Only heads compete for a free output; out-of-range ports match none.
    always_comb begin
        for (int o = 0; o < OUT_PORTS; o++) begin
            w_cand[o] = '0;
            for (int i = 0; i < IN_PORTS; i++) begin
                w_cand[o][i] = bus.req_valid[i] & bus.req_head[i]
                             & (w_port[i] == port_t'(o));
            end
        end
    end

    for (genvar o = 0; o < OUT_PORTS; o++) begin : g_arb
        rr_arbiter u_arb (
            .i_req (w_cand[o]),
            .i_ptr (r_ptr[o]),
            .o_gnt (w_arb_gnt[o]),
            .o_idx (w_arb_idx[o])
        );
    end

    always_comb begin
        w_grants = '0;
        w_fire   = '0;
        for (int o = 0; o < OUT_PORTS; o++) begin
            w_ogrant[o] = '0;
            if (w_en && bus.out_ready[o]) begin
                if (r_lock[o]) begin
                    if (bus.req_valid[r_owner[o]] &&
                        w_port[r_owner[o]] == port_t'(o))
                        w_ogrant[o][r_owner[o]] = 1'b1;
                end else begin
                    w_ogrant[o] = w_arb_gnt[o];
                end
            end
            w_fire[o] = |w_ogrant[o];
            w_grants  = w_grants | w_ogrant[o];
        end
    end

    always_comb begin
        for (int o = 0; o < OUT_PORTS; o++) w_lock_vec[o] = r_lock[o];
    end

    assign bus.grants      = w_grants;
    assign bus.grant_ports = bus.req_ports;
    assign bus.out_locked  = w_lock_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int o = 0; o < OUT_PORTS; o++) begin
                r_lock[o]  <= 1'b0;
                r_owner[o] <= '0;
                r_ptr[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < OUT_PORTS; o++) begin
                if (w_fire[o]) begin
                    if (r_lock[o]) begin
                        if (bus.req_tail[r_owner[o]]) r_lock[o] <= 1'b0;
                    end else begin
                        // Unlocked grants are always heads.
                        r_ptr[o]  <= next_idx(w_arb_idx[o]);
                        r_lock[o] <= ~bus.req_tail[w_arb_idx[o]];
                        if (!bus.req_tail[w_arb_idx[o]])
                            r_owner[o] <= w_arb_idx[o];
                    end
                end
            end
        end
    end

endmodule
